// File: rtl/argmax_stream_if.sv
// Score-in / result-out stream bundle for the argmax selector.
// The master side feeds scores and consumes results; the slave side is the selector.
interface argmax_stream_if #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 16
);
    localparam int IDX_W = $clog2(NUM_CLASSES);

    logic               in_valid;
    logic               in_ready;
    logic [SCORE_W-1:0] in_score;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [IDX_W-1:0]   out_index;
    logic [SCORE_W-1:0] out_score;
    logic [SCORE_W-1:0] out_margin;
    logic               out_err;

    modport master (
        output in_valid, in_score, in_last, out_ready,
        input  in_ready, out_valid, out_index, out_score, out_margin, out_err
    );

    modport slave (
        input  in_valid, in_score, in_last, out_ready,
        output in_ready, out_valid, out_index, out_score, out_margin, out_err
    );
endinterface

// File: rtl/argmax_stream.sv
// Streaming argmax: tracks best and runner-up over one score per beat.
// Emits the winning index, score and margin per vector on a held valid/ready output.
module argmax_stream #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 16,
    parameter int SIGNED      = 1,
    parameter int TIE_LOW     = 1
) (
    input logic           clk,
    input logic           rst,
    argmax_stream_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_CLASSES);
    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NUM_CLASSES - 1);
    localparam logic [SCORE_W-1:0] MIN_SCORE =
        (SIGNED != 0) ? {1'b1, {(SCORE_W-1){1'b0}}} : {SCORE_W{1'b0}};

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;

    state_t             state_q,      state_d;
    logic [IDX_W-1:0]   cnt_q,        cnt_d;
    logic [SCORE_W-1:0] best_q,       best_d;
    logic [SCORE_W-1:0] second_q,     second_d;
    logic [IDX_W-1:0]   best_idx_q,   best_idx_d;
    logic               out_valid_q,  out_valid_d;
    logic [IDX_W-1:0]   out_index_q,  out_index_d;
    logic [SCORE_W-1:0] out_score_q,  out_score_d;
    logic [SCORE_W-1:0] out_margin_q, out_margin_d;
    logic               out_err_q,    out_err_d;

    logic               in_ready_s;
    logic               accept_s;
    logic               at_end_s;
    logic [SCORE_W-1:0] nb_s;
    logic [SCORE_W-1:0] ns_s;
    logic [IDX_W-1:0]   ni_s;

    function automatic logic gt(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) > $signed(b);
        end else begin
            return a > b;
        end
    endfunction

    assign in_ready_s = rst && !(out_valid_q && !bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;
    assign at_end_s   = (cnt_q == LAST_CNT);

    // Top-two update including the current beat.
    always_comb begin
        nb_s = best_q;
        ns_s = second_q;
        ni_s = best_idx_q;
        if (state_q == S_IDLE) begin
            nb_s = bus.in_score;
            ns_s = MIN_SCORE;
            ni_s = {IDX_W{1'b0}};
        end else if (gt(bus.in_score, best_q)) begin
            nb_s = bus.in_score;
            ns_s = best_q;
            ni_s = cnt_q;
        end else if (bus.in_score == best_q) begin
            ns_s = bus.in_score;
            if (TIE_LOW == 0) begin
                ni_s = cnt_q;
            end else begin
                ni_s = best_idx_q;
            end
        end else if (gt(bus.in_score, second_q)) begin
            ns_s = bus.in_score;
        end else begin
            ns_s = second_q;
        end
    end

    // Next-state: accumulation, vector close and output hold/handover.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        best_d       = best_q;
        second_d     = second_q;
        best_idx_d   = best_idx_q;
        out_valid_d  = out_valid_q;
        out_index_d  = out_index_q;
        out_score_d  = out_score_q;
        out_margin_d = out_margin_q;
        out_err_d    = out_err_q;
        if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (accept_s) begin
            if (bus.in_last || at_end_s) begin
                // best >= second always, so the wrap-free SCORE_W-bit difference is exact.
                out_valid_d  = 1'b1;
                out_index_d  = ni_s;
                out_score_d  = nb_s;
                out_margin_d = nb_s - ns_s;
                out_err_d    = bus.in_last ^ at_end_s;
                state_d      = S_IDLE;
                cnt_d        = {IDX_W{1'b0}};
                best_d       = {SCORE_W{1'b0}};
                second_d     = {SCORE_W{1'b0}};
                best_idx_d   = {IDX_W{1'b0}};
            end else begin
                state_d    = S_ACC;
                cnt_d      = cnt_q + 1'b1;
                best_d     = nb_s;
                second_d   = ns_s;
                best_idx_d = ni_s;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= {IDX_W{1'b0}};
            best_q       <= {SCORE_W{1'b0}};
            second_q     <= {SCORE_W{1'b0}};
            best_idx_q   <= {IDX_W{1'b0}};
            out_valid_q  <= 1'b0;
            out_index_q  <= {IDX_W{1'b0}};
            out_score_q  <= {SCORE_W{1'b0}};
            out_margin_q <= {SCORE_W{1'b0}};
            out_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            best_q       <= best_d;
            second_q     <= second_d;
            best_idx_q   <= best_idx_d;
            out_valid_q  <= out_valid_d;
            out_index_q  <= out_index_d;
            out_score_q  <= out_score_d;
            out_margin_q <= out_margin_d;
            out_err_q    <= out_err_d;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_index  = out_index_q;
    assign bus.out_score  = out_score_q;
    assign bus.out_margin = out_margin_q;
    assign bus.out_err    = out_err_q;
endmodule

// File: tb/tb_argmax_stream.sv
// Bench for argmax_stream: two configurations share one stimulus stream and are
// compared every cycle against a vector-level model, plus hand-computed expectations.
module tb_argmax_stream;
    localparam int N = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [15:0] in_score;
    logic [15:0] vq[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    argmax_stream_if #(.NUM_CLASSES(N), .SCORE_W(5))  ia ();
    argmax_stream_if #(.NUM_CLASSES(N), .SCORE_W(16)) ib ();

    assign ia.in_valid  = in_valid;
    assign ia.in_last   = in_last;
    assign ia.in_score  = in_score[4:0];
    assign ia.out_ready = out_ready;
    assign ib.in_valid  = in_valid;
    assign ib.in_last   = in_last;
    assign ib.in_score  = in_score;
    assign ib.out_ready = out_ready;

    argmax_stream #(.NUM_CLASSES(N), .SCORE_W(5), .SIGNED(0), .TIE_LOW(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ia.slave));
    argmax_stream #(.NUM_CLASSES(N), .SCORE_W(16), .SIGNED(1), .TIE_LOW(0)) dut_b (
        .clk(clk), .rst(rst), .bus(ib.slave));

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Vector-level reference: max, tie rule, and max of the rest after removing one winner.
    function automatic void model_result(input logic [15:0] v[N], input int n, input int w,
                                         input bit sgn, input bit tlow, output longint idx,
                                         output longint sc, output longint mg);
        longint mask, half, best, sec;
        longint vals[N];
        bit removed;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        for (int i = 0; i < n; i++) begin
            vals[i] = longint'(v[i]) & mask;
            if (sgn && vals[i] >= half) vals[i] = vals[i] - (mask + 1);
        end
        best = vals[0];
        for (int i = 1; i < n; i++) if (vals[i] > best) best = vals[i];
        idx = -1;
        for (int i = 0; i < n; i++)
            if (vals[i] == best && (idx < 0 || !tlow)) idx = i;
        sec = sgn ? -half : 0;
        removed = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (vals[i] == best && !removed) removed = 1'b1;
            else if (vals[i] > sec) sec = vals[i];
        end
        mg = best - sec;
        sc = best & mask;
    endfunction

    logic [15:0] beats[N];
    int     nbeats;
    bit     mv, zflag, armed = 1'b0;
    bit     e_err;
    longint ea_idx, ea_sc, ea_mg, eb_idx, eb_sc, eb_mg;
    logic   exp_ready;

    assign exp_ready = rst && !(mv && !out_ready);

    // Reference model advances on every rising edge.
    always @(posedge clk) begin : model
        logic [15:0] tmp[N];
        longint ai, as_, am, bi, bs, bm;
        if (!rst) begin
            mv <= 1'b0; zflag <= 1'b1; armed <= 1'b1; nbeats <= 0; e_err <= 1'b0;
            ea_idx <= 0; ea_sc <= 0; ea_mg <= 0; eb_idx <= 0; eb_sc <= 0; eb_mg <= 0;
        end else begin
            if (out_ready) mv <= 1'b0;
            if (in_valid && !(mv && !out_ready)) begin
                tmp = beats;
                tmp[nbeats] = in_score;
                beats[nbeats] <= in_score;
                if (in_last || nbeats == N - 1) begin
                    model_result(tmp, nbeats + 1, 5, 1'b0, 1'b1, ai, as_, am);
                    model_result(tmp, nbeats + 1, 16, 1'b1, 1'b0, bi, bs, bm);
                    ea_idx <= ai; ea_sc <= as_; ea_mg <= am;
                    eb_idx <= bi; eb_sc <= bs; eb_mg <= bm;
                    e_err  <= !(in_last && nbeats == N - 1);
                    mv <= 1'b1; zflag <= 1'b0; nbeats <= 0;
                end else begin
                    nbeats <= nbeats + 1;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("a_in_ready", ia.in_ready, exp_ready);
            chk("b_in_ready", ib.in_ready, exp_ready);
            chk("a_out_valid", ia.out_valid, mv);
            chk("b_out_valid", ib.out_valid, mv);
            if (mv || zflag) begin
                chk("a_index", ia.out_index, ea_idx);
                chk("a_score", ia.out_score, ea_sc);
                chk("a_margin", ia.out_margin, ea_mg);
                chk("a_err", ia.out_err, zflag ? 0 : e_err);
                chk("b_index", ib.out_index, eb_idx);
                chk("b_score", ib.out_score, eb_sc);
                chk("b_margin", ib.out_margin, eb_mg);
                chk("b_err", ib.out_err, zflag ? 0 : e_err);
            end
        end
    end

    task automatic send_beat(input logic [15:0] s, input bit l);
        int tries;
        in_valid = 1'b1; in_score = s; in_last = l;
        tries = 0;
        @(negedge clk);
        while (!exp_ready && tries < 40) begin
            @(negedge clk);
            tries++;
        end
        if (!exp_ready) begin
            checks++; errors++;
            $display("FAIL beat_timeout: in_ready stayed %0d for %0d cycles", exp_ready, tries);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_vec(input bit last_at_end);
        for (int i = 0; i < vq.size(); i++) send_beat(vq[i], last_at_end && (i == vq.size() - 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0; in_last = 1'b0; in_score = 16'd0; out_ready = 1'b1; rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", ia.in_ready, 0);
        chk("rst_out_valid", ib.out_valid, 0);
        chk("rst_margin", ib.out_margin, 0);
        @(posedge clk); #1 rst = 1'b1;

        vq = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10};
        send_vec(1'b1);
        @(negedge clk);
        chk("ramp_valid", ia.out_valid, 1);
        chk("ramp_index", ia.out_index, 9);
        chk("ramp_score", ia.out_score, 10);
        chk("ramp_margin", ia.out_margin, 1);
        chk("ramp_err", ia.out_err, 0);
        @(posedge clk); #1;

        vq = '{16'd1, 16'd3, 16'd7, 16'd2, 16'd4, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0};
        send_vec(1'b1);
        @(negedge clk);
        chk("tie_low_index", ia.out_index, 2);
        chk("tie_low_margin", ia.out_margin, 0);
        chk("tie_high_index", ib.out_index, 5);
        chk("model_pin_tie_high", eb_idx, 5);
        @(posedge clk); #1;

        vq = '{16'hFFFB, 16'hFFFA, 16'hFFF9, 16'hFFF8, 16'hFFF7,
               16'hFFF6, 16'hFFF5, 16'hFFF4, 16'hFFF3, 16'hFFF2};
        send_vec(1'b1);
        @(negedge clk);
        chk("neg_index", ib.out_index, 0);
        chk("neg_score", ib.out_score, 16'hFFFB);
        chk("neg_margin", ib.out_margin, 1);
        chk("neg_unsigned_score", ia.out_score, 27);
        @(posedge clk); #1;

        vq = '{16'hFFFD, 16'd20, 16'hFFF9, 16'hFFF8, 16'hFFFE,
               16'hFFF7, 16'hFFFC, 16'hFFFB, 16'hFFFA, 16'hFFFF};
        send_vec(1'b1);
        @(negedge clk);
        chk("mix_index", ib.out_index, 1);
        chk("mix_margin", ib.out_margin, 21);
        chk("model_pin_mix_margin", eb_mg, 21);
        @(posedge clk); #1;

        vq = '{16'd7};  send_vec(1'b1);
        vq = '{16'd3};  send_vec(1'b1);
        vq = '{16'd12}; send_vec(1'b1);
        @(negedge clk);
        chk("single_valid", ia.out_valid, 1);
        chk("single_score", ia.out_score, 12);
        chk("single_err", ia.out_err, 1);
        chk("single_signed_margin", ib.out_margin, 32780);
        @(posedge clk); #1;

        out_ready = 1'b0;
        vq = '{16'd3, 16'd1, 16'd4, 16'd1, 16'd5, 16'd9, 16'd2, 16'd6, 16'd5, 16'd3};
        send_vec(1'b1);
        @(negedge clk);
        chk("bp_index", ia.out_index, 5);
        chk("bp_margin", ia.out_margin, 3);
        fork
            begin
                repeat (2) @(negedge clk);
                chk("bp_stall_in_ready", ia.in_ready, 0);
                chk("bp_held_index", ib.out_index, 5);
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join_none
        vq = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd0};
        send_vec(1'b1);
        @(negedge clk);
        chk("bp_next_index", ia.out_index, 8);
        chk("bp_next_margin", ib.out_margin, 1);
        @(posedge clk); #1;

        vq = '{16'd2, 16'd9, 16'd1, 16'd0, 16'd3};
        send_vec(1'b1);
        @(negedge clk);
        chk("short_err", ia.out_err, 1);
        chk("short_index", ia.out_index, 1);
        @(posedge clk); #1;

        vq = '{16'd4, 16'd8, 16'd15, 16'd16, 16'd23, 16'd2, 16'd1, 16'd0, 16'd3, 16'd5};
        send_vec(1'b0);
        @(negedge clk);
        chk("nolast_valid", ia.out_valid, 1);
        chk("nolast_err", ia.out_err, 1);
        chk("nolast_index", ia.out_index, 4);
        chk("nolast_margin", ia.out_margin, 7);
        @(posedge clk); #1;

        vq = '{16'd5, 16'd5, 16'd5, 16'd5, 16'd5};
        send_vec(1'b0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid", ia.out_valid, 0);
        chk("mid_rst_index", ia.out_index, 0);
        chk("mid_rst_score", ib.out_score, 0);
        chk("mid_rst_err", ib.out_err, 0);
        @(posedge clk); #1 rst = 1'b1;
        vq = '{16'd0, 16'd0, 16'd0, 16'd6, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        send_vec(1'b1);
        @(negedge clk);
        chk("post_rst_index", ia.out_index, 3);
        chk("post_rst_margin", ia.out_margin, 6);
        chk("post_rst_err", ib.out_err, 0);
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/argmax_stream.md
# argmax_stream

Parametrised streaming argmax selector. It is the successor to the fixed 10-way max selector on the classifier output path. Class scores arrive serially over a valid/ready stream, one score per beat. For each vector of NUM_CLASSES scores the block returns the winning class index, the winning score and the confidence margin (best minus runner-up), held on a valid/ready output until consumed.

## Interface
- NUM_CLASSES, 10: scores per vector; legal range 2..256.
- SCORE_W, 16: score width in bits.
- SIGNED, 1: 1 = scores are two's complement; 0 = unsigned.
- TIE_LOW, 1: 1 = a tie keeps the lower index; 0 = a tie takes the higher index.
- IDX_W (derived, not overridable): $clog2(NUM_CLASSES).

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  in  1  score beat present.
- in_ready  out  1  block accepts the beat this cycle.
- in_score  in  SCORE_W  class score; beat k carries class k.
- in_last  in  1  marks the final beat of a vector.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts the result.
- out_index  out  IDX_W  winning class index.
- out_score  out  SCORE_W  winning score.
- out_margin  out  SCORE_W  unsigned best minus runner-up.
- out_err  out  1  vector length error.

## Operation
- A beat is accepted when in_valid && in_ready. The beat counter cnt starts at 0 and increments on every accepted beat.
- The state machine has two states:
  - S_IDLE: cnt = 0.
  - S_ACC: a vector is in progress.
  - S_IDLE → S_ACC on an accepted non-final beat.
  - S_ACC → S_IDLE on an accepted final beat.
- A final beat is the accepted beat with in_last = 1, or the beat with cnt = NUM_CLASSES-1, whichever comes first.
- First beat of a vector: best = score, best_idx = 0, second = minimum representable value (0 if unsigned, -2^(SCORE_W-1) if signed).
- Subsequent beats, with all compares signed or unsigned according to SIGNED:
  - score > best: second = best, then best = score and best_idx = cnt.
  - score == best: if TIE_LOW = 0, best_idx = cnt; in either case second = score.
  - Otherwise, if score > second: second = score.
- Final beat: the output registers load best_idx, best and (best - second) using the updated values, i.e. the final beat itself is included.
  - The subtraction is done at SCORE_W+1 bits; the result is always ≥ 0 and fits in SCORE_W unsigned bits.
  - The accumulation registers are cleared and cnt returns to 0.
- out_err = 1 when in_last arrives with cnt < NUM_CLASSES-1, or when beat NUM_CLASSES-1 arrives with in_last = 0. In both cases the result is still produced over the beats received.
- in_ready = rst && !(out_valid && !out_ready).

## Timing
- Latency: out_valid rises on the cycle after the final beat is accepted. There is no combinational path from in_* to out_*.
- The out_* values are stable while out_valid && !out_ready. out_valid clears on the cycle after the out_ready handshake, unless a new final beat is accepted in the same cycle, in which case new values load with no bubble.
- Back-to-back vectors are accepted at one beat per cycle while out_ready = 1.
- Backpressure: while a result is held unconsumed, in_ready = 0, so no beat is lost and no result is overwritten. Non-final beats are also stalled.
- Reset (rst = 0 at a clock edge):
  - out_valid, out_index, out_score, out_margin, out_err, cnt and the accumulators all go to 0; the state goes to S_IDLE.
  - in_ready = 0 while rst = 0.
- Reset mid-vector discards the partial vector; the next accepted beat is class 0.
- Simultaneous output handshake and final-beat acceptance: the new result loads and out_valid stays 1.

## Test plan
- Unsigned, SCORE_W = 5, scores 1..10 with in_last on beat 9, out_ready = 1 -> the cycle after beat 9: out_valid = 1, out_index = 9, out_score = 10, out_margin = 1, out_err = 0.
- Ties, TIE_LOW = 1, scores {1,3,7,2,4,7,0,0,0,0} -> out_index = 2, out_margin = 0. With TIE_LOW = 0 -> out_index = 5.
- SIGNED = 1, scores -5,-6,...,-14 -> out_index = 0, out_score = -5, out_margin = 1. Also scores {-3,20,...,-1} with all others negative -> out_index = 1, out_margin = 21.
- Backpressure: out_ready = 0 for 4 cycles after the result while the next vector is offered -> in_ready = 0, outputs unchanged; after out_ready = 1, the next vector completes with the correct index and no dropped beat.
- Length errors:
  - in_last on beat 4 of {2,9,1,0,3} -> out_err = 1, out_index = 1.
  - Ten beats with no in_last -> out_err = 1 on beat 9 and the result is produced.
- Reset: rst = 0 after 5 beats of a vector -> all outputs 0 on the next edge. A fresh 10-beat vector {0,...,0,6 at index 3} -> out_index = 3.
